// File: rtl/keypad_scanner_pkg.sv
// Shared types for the keypad scanner: debounce states, frame classification
// and the row/column to hex-code map.
package keypad_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        HELD,
        RELEASE_PEND
    } deb_state_e;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } frame_result_e;

    // Nibble i holds the code for frame bit i = {row, col}; row 0 is the low word.
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] key_lookup(input logic [3:0] idx);
        return KEY_MAP[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle. The slave side is the scanner itself; the
// master side is the keypad / board logic that consumes key events.
interface keypad_scanner_if;
    logic                    clr;
    logic [3:0]              col;
    logic [3:0]              row;
    logic                    key_valid;
    logic [3:0]              key_code;
    logic                    key_down;
    logic [31:0]             entry;
    keypad_pkg::deb_state_e  dbg_state;

    // key_valid is a single-cycle strobe with no back-pressure: a consumer
    // must take key_code/entry in the cycle key_valid is high.
    modport master (
        output clr, col,
        input  row, key_valid, key_code, key_down, entry, dbg_state
    );

    modport slave (
        input  clr, col,
        output row, key_valid, key_code, key_down, entry, dbg_state
    );
endinterface

// File: rtl/keypad_debounce.sv
// Per-frame debounce FSM for the keypad scanner. Auto-repeat while a key is
// held is built only when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE     = 20,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_frame_done,
    input  frame_result_e i_result,
    input  logic [3:0]    i_code,
    output logic          o_accept,
    output logic          o_event,
    output logic [3:0]    o_code,
    output logic          o_key_down,
    output deb_state_e    o_state
);
    localparam logic [15:0] DEB = 16'(DEBOUNCE);

    deb_state_e r_state;
    logic [15:0] r_cnt;
    logic [3:0]  r_cand;
    logic        r_event;
    logic [3:0]  r_code;

    logic w_single;
    logic w_match;
    logic w_press;
    logic w_repeat;

    assign w_single = i_frame_done && (i_result == SINGLE);
    assign w_match  = w_single && (i_code == r_cand);
    assign w_press  = ((r_state == RELEASED) && w_single && (DEB == 16'd1)) ||
                      ((r_state == PRESS_PEND) && w_match && (r_cnt + 16'd1 == DEB));

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [15:0] REP_FIRST = 16'(REPEAT_DELAY);
    localparam logic [15:0] REP_NEXT  = 16'(REPEAT_RATE);

    logic [15:0] r_rep;
    logic        r_rep_armed;

    assign w_repeat = (r_state == HELD) && w_match &&
                      (r_rep_armed ? (r_rep + 16'd1 == REP_NEXT) : (r_rep + 16'd1 == REP_FIRST));

    // Held frames of any other result leave the counter untouched.
    always_ff @(posedge clk) begin
        if (reset || w_press || (r_state != HELD)) begin
            r_rep       <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_match) begin
            if (w_repeat) begin
                r_rep       <= '0;
                r_rep_armed <= 1'b1;
            end else begin
                r_rep <= r_rep + 16'd1;
            end
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    // o_accept is the combinational strobe during EVAL so the entry shift
    // lands on the same edge that raises o_event.
    assign o_accept   = w_press || w_repeat;
    assign o_event    = r_event;
    assign o_code     = r_code;
    assign o_key_down = (r_state == HELD) || (r_state == RELEASE_PEND);
    assign o_state    = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
            r_cand  <= '0;
            r_event <= 1'b0;
            r_code  <= '0;
        end else begin
            r_event <= o_accept;
            if (o_accept) r_code <= i_code;
            if (i_frame_done) begin
                case (r_state)
                    RELEASED: begin
                        if (w_single) begin
                            r_cand <= i_code;
                            if (w_press) begin
                                r_state <= HELD;
                                r_cnt   <= '0;
                            end else begin
                                r_state <= PRESS_PEND;
                                r_cnt   <= 16'd1;
                            end
                        end
                    end
                    PRESS_PEND: begin
                        if (w_match) begin
                            if (w_press) begin
                                r_state <= HELD;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 16'd1;
                            end
                        end else begin
                            r_state <= RELEASED;
                            r_cnt   <= '0;
                        end
                    end
                    HELD: begin
                        if (i_result == NONE) begin
                            if (DEB == 16'd1) begin
                                r_state <= RELEASED;
                                r_cnt   <= '0;
                            end else begin
                                r_state <= RELEASE_PEND;
                                r_cnt   <= 16'd1;
                            end
                        end
                    end
                    RELEASE_PEND: begin
                        if (i_result == NONE) begin
                            if (r_cnt + 16'd1 == DEB) begin
                                r_state <= RELEASED;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 16'd1;
                            end
                        end else begin
                            r_state <= HELD;
                            r_cnt   <= '0;
                        end
                    end
                    default: begin
                        r_state <= RELEASED;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: row scan, column sync, frame classification and the
// 32-bit entry shift register. Optional auto-repeat: KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 25000,
    parameter int DEBOUNCE     = 20,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic            clk,
    input  logic            reset,
    keypad_scanner_if.slave bus
);
    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [3:0]       r_col_meta;
    logic [3:0]       r_col_sync;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_row_idx;
    logic [3:0]       r_row;
    logic [15:0]      r_frame;
    logic             r_frame_done;
    logic [31:0]      r_entry;

    logic          w_tick;
    logic [1:0]    w_next_idx;
    logic [4:0]    w_ones;
    logic [3:0]    w_idx;
    frame_result_e w_result;
    logic [3:0]    w_code;
    logic          w_accept;

    assign w_tick     = (r_div == DIV_LAST);
    assign w_next_idx = r_row_idx + 2'd1;

    // Columns are sampled at the end of each row slot, well after the row drive
    // and the two synchronizer stages have settled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col_meta   <= 4'hF;
            r_col_sync   <= 4'hF;
            r_div        <= '0;
            r_row_idx    <= 2'd0;
            r_row        <= 4'b1110;
            r_frame      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_col_meta   <= bus.col;
            r_col_sync   <= r_col_meta;
            r_frame_done <= w_tick && (r_row_idx == 2'd3);
            if (w_tick) begin
                r_div                          <= '0;
                r_frame[{r_row_idx, 2'b00} +: 4] <= ~r_col_sync;
                r_row_idx                      <= w_next_idx;
                r_row                          <= ~(4'b0001 << w_next_idx);
            end else begin
                r_div <= r_div + DIV_ONE;
            end
        end
    end

    always_comb begin
        w_ones = '0;
        w_idx  = '0;
        for (int i = 0; i < 16; i++) begin
            if (r_frame[i]) begin
                w_ones = w_ones + 5'd1;
                w_idx  = 4'(i);
            end
        end
        if (w_ones == 5'd0)      w_result = NONE;
        else if (w_ones == 5'd1) w_result = SINGLE;
        else                     w_result = MULTI;
        w_code = key_lookup(w_idx);
    end

    keypad_debounce #(
        .DEBOUNCE     (DEBOUNCE),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_debounce (
        .clk          (clk),
        .reset        (reset),
        .i_frame_done (r_frame_done),
        .i_result     (w_result),
        .i_code       (w_code),
        .o_accept     (w_accept),
        .o_event      (bus.key_valid),
        .o_code       (bus.key_code),
        .o_key_down   (bus.key_down),
        .o_state      (bus.dbg_state)
    );

    // clr takes priority over a coinciding key event.
    always_ff @(posedge clk) begin
        if (reset || bus.clr) begin
            r_entry <= '0;
        end else if (w_accept) begin
            r_entry <= {r_entry[27:0], w_code};
        end
    end

    assign bus.row   = r_row;
    assign bus.entry = r_entry;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3; repeat
// expectations follow KEYPAD_AUTOREPEAT_EN (REPEAT_DELAY=5, REPEAT_RATE=2).
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] keys = '0;
    logic [3:0]  col_drive;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulses = 0;
    logic [31:0] exp_entry = '0;
    logic [35:0] exp_q[$];

    keypad_scanner_if bus ();

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE     (3),
        .REPEAT_DELAY (5),
        .REPEAT_RATE  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Passive keypad: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_drive = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!bus.row[r] && keys[4*r+c]) col_drive[c] = 1'b0;
    end
    assign bus.col = col_drive;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] key_mask(input logic [3:0] code);
        case (code)
            4'h1: key_mask = 16'h0001;  4'h2: key_mask = 16'h0002;
            4'h3: key_mask = 16'h0004;  4'hA: key_mask = 16'h0008;
            4'h4: key_mask = 16'h0010;  4'h5: key_mask = 16'h0020;
            4'h6: key_mask = 16'h0040;  4'hB: key_mask = 16'h0080;
            4'h7: key_mask = 16'h0100;  4'h8: key_mask = 16'h0200;
            4'h9: key_mask = 16'h0400;  4'hC: key_mask = 16'h0800;
            4'h0: key_mask = 16'h1000;  4'hF: key_mask = 16'h2000;
            4'hE: key_mask = 16'h4000;  default: key_mask = 16'h8000;
        endcase
    endfunction

    task automatic expect_press(input logic [3:0] code, input logic clr_on);
        exp_entry = clr_on ? 32'h0 : {exp_entry[27:0], code};
        exp_q.push_back({code, exp_entry});
    endtask

    // Returns at the first negedge after row 0 becomes driven again.
    task automatic wait_frame_start();
        int n = 0;
        while (bus.row == 4'b1110 && n < 64) begin @(negedge clk); n++; end
        while (bus.row != 4'b1110 && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) begin
            n_checks++;
            $display("FAIL frame_timeout: row %b after %0d cycles, required 1110", bus.row, n);
        end
    endtask

    task automatic frames(input logic [15:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            wait_frame_start();
            keys = mask;
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
    endtask

    initial begin : monitor
        logic [35:0] e;
        forever begin
            @(negedge clk);
            if (!reset && bus.key_valid) begin
                n_pulses++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pulse: code %0h entry %0h, no event required",
                             bus.key_code, bus.entry);
                end else begin
                    e = exp_q.pop_front();
                    chk("key_event", {bus.key_code, bus.entry}, e);
                end
            end
        end
    end

    initial begin : stimulus
        int p0;
        logic [3:0] digits [9];
        digits = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        bus.clr = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_row", bus.row, 4'b1110);
        chk("reset_valid", bus.key_valid, 1'b0);
        chk("reset_code", bus.key_code, 4'h0);
        chk("reset_down", bus.key_down, 1'b0);
        chk("reset_entry", bus.entry, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rot_row0", bus.row, 4'b1110);
        repeat (3) @(negedge clk);
        chk("rot_row1", bus.row, 4'b1101);
        repeat (4) @(negedge clk);
        chk("rot_row2", bus.row, 4'b1011);
        repeat (4) @(negedge clk);
        chk("rot_row3", bus.row, 4'b0111);
        repeat (4) @(negedge clk);
        chk("rot_wrap", bus.row, 4'b1110);

        // Key 5 held 12 frames; repeats land on held frames 5, 7, 9 when enabled.
        expect_press(4'h5, 1'b0);
`ifdef KEYPAD_AUTOREPEAT_EN
        for (int i = 0; i < 3; i++) expect_press(4'h5, 1'b0);
`endif
        frames(key_mask(4'h5), 2);
        wait_frame_start(); settle();
        chk("k5_no_early_pulse", n_pulses, 0);
        chk("k5_down_pending", bus.key_down, 1'b0);
        wait_frame_start(); settle();
        chk("k5_pulse_at_eval3", n_pulses, 1);
        chk("k5_down_held", bus.key_down, 1'b1);
        chk("k5_code", bus.key_code, 4'h5);
        frames(key_mask(4'h5), 8);
        frames(16'h0, 2);
        wait_frame_start(); settle();
        chk("k5_down_release_pend", bus.key_down, 1'b1);
        wait_frame_start(); settle();
        chk("k5_down_released", bus.key_down, 1'b0);
        chk("k5_entry", bus.entry, exp_entry);
`ifdef KEYPAD_AUTOREPEAT_EN
        chk("k5_pulse_count", n_pulses, 4);
`else
        chk("k5_pulse_count", n_pulses, 1);
`endif

        // Bounce on key 7: the broken run must not count toward acceptance.
        pulse_clr();
        exp_entry = '0;
        p0 = n_pulses;
        expect_press(4'h7, 1'b0);
        frames(key_mask(4'h7), 2);
        frames(16'h0, 1);
        frames(key_mask(4'h7), 2);
        wait_frame_start(); settle();
        chk("bounce_no_pulse", n_pulses, p0);
        wait_frame_start(); settle();
        chk("bounce_one_pulse", n_pulses, p0 + 1);
        chk("bounce_entry", bus.entry, 32'h7);
        frames(16'h0, 3);

        // Nine clean digits overflow the eight-nibble entry.
        pulse_clr();
        exp_entry = '0;
        p0 = n_pulses;
        for (int i = 0; i < 9; i++) begin
            expect_press(digits[i], 1'b0);
            frames(key_mask(digits[i]), 3);
            frames(16'h0, 3);
        end
        wait_frame_start(); settle();
        chk("digits_pulses", n_pulses, p0 + 9);
        chk("digits_entry", bus.entry, 32'h23AB_CDEF);
        pulse_clr();
        @(negedge clk);
        chk("clr_entry", bus.entry, 32'h0);
        exp_entry = '0;

        // Keys 1 and 2 together are ghosting and never accepted.
        p0 = n_pulses;
        frames(key_mask(4'h1) | key_mask(4'h2), 5);
        wait_frame_start(); settle();
        chk("multi_down_mid", bus.key_down, 1'b0);
        frames(key_mask(4'h1) | key_mask(4'h2), 4);
        wait_frame_start(); settle();
        chk("multi_no_pulse", n_pulses, p0);
        chk("multi_down_end", bus.key_down, 1'b0);
        frames(16'h0, 1);

        // clr held across a press of E: event still reported, entry stays zero.
        @(negedge clk);
        bus.clr = 1'b1;
        p0 = n_pulses;
        expect_press(4'hE, 1'b1);
        frames(key_mask(4'hE), 3);
        wait_frame_start(); settle();
        bus.clr = 1'b0;
        chk("clr_press_pulse", n_pulses, p0 + 1);
        chk("clr_press_code", bus.key_code, 4'hE);
        chk("clr_press_entry", bus.entry, 32'h0);
        frames(16'h0, 3);
        wait_frame_start(); settle();

        // Reset during PRESS_PEND aborts the pending press.
        p0 = n_pulses;
        frames(key_mask(4'h2), 2);
        wait_frame_start(); settle();
        chk("rst_pend_state", bus.dbg_state, PRESS_PEND);
        reset = 1'b1;
        keys = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_row", bus.row, 4'b1110);
        chk("rst_valid", bus.key_valid, 1'b0);
        chk("rst_code", bus.key_code, 4'h0);
        chk("rst_down", bus.key_down, 1'b0);
        chk("rst_entry", bus.entry, 32'h0);
        frames(16'h0, 4);
        wait_frame_start(); settle();
        chk("rst_no_pulse", n_pulses, p0);

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
